// File: rtl/ddr_refresh_arbiter_pkg.sv
// Shared DDR uop encoding: field layout, refresh FSM states and the fixed
// NOP / PRE-all / REF bundles the arbiter drives toward ddr_pipeline.
package ddr_refresh_arbiter_pkg;

  localparam int DDR_UOP_WIDTH = 32;
  localparam int DDR_SLOTS     = 4;
  localparam int DDR_BUNDLE_W  = DDR_SLOTS * DDR_UOP_WIDTH;

  // One uop slot; bit 0 is IS_NOP, register ids occupy the upper bytes.
  typedef struct packed {
    logic [7:0] rs2_id;
    logic [7:0] rs1_id;
    logic [7:0] rd_id;
    logic [2:0] hbm_channel;
    logic       is_rank;
    logic       is_ref;
    logic       pre_all;
    logic       is_pre;
    logic       is_nop;
  } ddr_uop_t;

  typedef logic [DDR_BUNDLE_W-1:0] ddr_bundle_t;
  typedef logic [3:0]              ref_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREA     = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_REF      = 3'd3,
    ST_WAIT_RFC = 3'd4
  } ref_state_e;

  // Refresh uops: rank 0, channel 0, all register ids 0.
  localparam ddr_uop_t UOP_NOP  = '{is_nop: 1'b1, default: '0};
  localparam ddr_uop_t UOP_PREA = '{is_pre: 1'b1, pre_all: 1'b1, default: '0};
  localparam ddr_uop_t UOP_REF  = '{is_ref: 1'b1, default: '0};

  // Slot 0 sits in the least significant bits.
  localparam ddr_bundle_t BUNDLE_NOP  = {UOP_NOP, UOP_NOP, UOP_NOP, UOP_NOP};
  localparam ddr_bundle_t BUNDLE_PREA = {UOP_NOP, UOP_NOP, UOP_NOP, UOP_PREA};
  localparam ddr_bundle_t BUNDLE_REF  = {UOP_NOP, UOP_NOP, UOP_NOP, UOP_REF};

endpackage

// File: rtl/ddr_refresh_arbiter_tick.sv
// refresh_tick_gen: tREFI interval counter plus the postponed-refresh count.
// A tick and an issued REF in the same cycle cancel out.
module refresh_tick_gen
  import ddr_refresh_arbiter_pkg::*;
#(
  parameter int TREFI        = 7800,
  parameter int MAX_POSTPONE = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     refresh_en_i,
  input  logic     issue_i,
  output ref_cnt_t pending_o
);

  localparam int                TW    = $clog2(TREFI);
  localparam logic [TW-1:0]     TLAST = TW'(TREFI - 1);
  localparam ref_cnt_t          PMAX  = 4'(MAX_POSTPONE);

  logic [TW-1:0] tcnt_q, tcnt_d;
  ref_cnt_t      pend_q, pend_d;
  logic          tick;

  // Interval counter freezes while disabled; pending saturates at the force level.
  always_comb begin
    tick   = refresh_en_i && (tcnt_q == TLAST);
    tcnt_d = tcnt_q;
    if (refresh_en_i) tcnt_d = tick ? '0 : tcnt_q + TW'(1);
    pend_d = pend_q;
    if (tick && !issue_i)      pend_d = (pend_q >= PMAX) ? PMAX : pend_q + 4'd1;
    else if (!tick && issue_i) pend_d = pend_q - 4'd1;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
      pend_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/ddr_refresh_arbiter.sv
// ddr_refresh_arbiter: splices PRE-all / REF sequences into the execute-stage
// uop stream. Refreshes go opportunistically on idle cycles, or are forced
// once the postponed count hits MAX_POSTPONE. Output bundle is registered.
module ddr_refresh_arbiter
  import ddr_refresh_arbiter_pkg::*;
#(
  parameter int TREFI        = 7800,
  parameter int TRP          = 12,
  parameter int TRFC         = 280,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    refresh_en_i,
  input  logic                    exe_valid_i,
  input  logic [DDR_BUNDLE_W-1:0] exe_uop_i,
  output logic                    exe_ready_o,
  output logic                    ddr_valid_o,
  output logic [DDR_BUNDLE_W-1:0] ddr_uop_o,
  output logic [3:0]              ref_pending_o,
  output logic                    ref_busy_o,
  output logic                    ref_issued_o
);

  localparam int            WMAX     = (TRP > TRFC) ? TRP : TRFC;
  localparam int            WW       = $clog2(WMAX);
  // Counter is loaded with len-2 and the state exits on zero: len-1 cycles.
  localparam logic [WW-1:0] RP_LOAD  = WW'(TRP - 2);
  localparam logic [WW-1:0] RFC_LOAD = WW'(TRFC - 2);
  localparam ref_cnt_t      PMAX     = 4'(MAX_POSTPONE);

  ref_state_e    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  ddr_bundle_t   uop_q, uop_d;
  logic          valid_q, valid_d;
  logic          issued_q, issued_d;
  ref_cnt_t      pending;
  logic          start_ref;
  logic          accept;

  refresh_tick_gen #(
    .TREFI        (TREFI),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_tick (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .refresh_en_i (refresh_en_i),
    .issue_i      (state_q == ST_REF),
    .pending_o    (pending)
  );

  assign start_ref   = (pending != '0) && (!exe_valid_i || pending == PMAX);
  assign exe_ready_o = rst_ni && (state_q == ST_IDLE) && !start_ref;
  assign accept      = exe_valid_i && exe_ready_o;

  // Next state; the shared wait counter reloads on entry to each wait state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE:     if (start_ref) state_d = ST_PREA;
      ST_PREA:     begin state_d = ST_WAIT_RP; wcnt_d = RP_LOAD; end
      ST_WAIT_RP:  if (wcnt_q == '0) state_d = ST_REF;
                   else wcnt_d = wcnt_q - WW'(1);
      ST_REF:      begin state_d = ST_WAIT_RFC; wcnt_d = RFC_LOAD; end
      ST_WAIT_RFC: if (wcnt_q == '0) state_d = start_ref ? ST_PREA : ST_IDLE;
                   else wcnt_d = wcnt_q - WW'(1);
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output bundle keyed off the next state so it lines up with state_q.
  always_comb begin
    valid_d  = 1'b0;
    uop_d    = BUNDLE_NOP;
    issued_d = 1'b0;
    case (state_d)
      ST_PREA: begin valid_d = 1'b1; uop_d = BUNDLE_PREA; end
      ST_REF:  begin valid_d = 1'b1; uop_d = BUNDLE_REF; issued_d = 1'b1; end
      ST_IDLE: if (accept) begin valid_d = 1'b1; uop_d = exe_uop_i; end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      uop_q    <= BUNDLE_NOP;
      valid_q  <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      uop_q    <= uop_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
    end
  end

  assign ddr_valid_o   = valid_q;
  assign ddr_uop_o     = uop_q;
  assign ref_pending_o = pending;
  assign ref_busy_o    = (state_q != ST_IDLE);
  assign ref_issued_o  = issued_q;

endmodule

// File: tb/tb_ddr_refresh_arbiter.sv
// Bench for ddr_refresh_arbiter with TREFI=100, TRP=5, TRFC=20, MAX_POSTPONE=8.
// Cycle c counts rising edges since reset release.
module tb_ddr_refresh_arbiter;

  localparam int TREFI = 100;
  localparam int TRP   = 5;
  localparam int TRFC  = 20;
  localparam int MAXP  = 8;
  localparam int SEQ   = TRP + TRFC;   // cycles from PREA through last tRFC wait

  localparam logic [127:0] NOP_B  = {32'h1, 32'h1, 32'h1, 32'h1};
  localparam logic [127:0] PREA_B = {32'h1, 32'h1, 32'h1, 32'h6};
  localparam logic [127:0] REF_B  = {32'h1, 32'h1, 32'h1, 32'h8};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         exe_valid = 1'b0;
  logic [127:0] exe_uop = '0;
  logic         exe_ready, ddr_valid, ref_busy, ref_issued;
  logic [127:0] ddr_uop;
  logic [3:0]   ref_pending;

  int checks = 0;
  int failures = 0;

  // model state: tick count, pending, offset into a refresh sequence (-1 = idle)
  int           m_tcnt, m_pend, m_off;
  bit           m_vld;
  logic [127:0] m_uop;

  ddr_refresh_arbiter #(
    .TREFI(TREFI), .TRP(TRP), .TRFC(TRFC), .MAX_POSTPONE(MAXP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .refresh_en_i (en),
    .exe_valid_i  (exe_valid),
    .exe_uop_i    (exe_uop),
    .exe_ready_o  (exe_ready),
    .ddr_valid_o  (ddr_valid),
    .ddr_uop_o    (ddr_uop),
    .ref_pending_o(ref_pending),
    .ref_busy_o   (ref_busy),
    .ref_issued_o (ref_issued)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exe_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rnd_bundle();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_tcnt = 0; m_pend = 0; m_off = -1; m_vld = 1'b0; m_uop = NOP_B;
  endtask

  // Advance the reference model one cycle using the inputs driven this cycle.
  task automatic model_step(input bit go, input bit rdy);
    bit tick, issue;
    int noff;
    tick  = en && (m_tcnt == TREFI - 1);
    issue = (m_off == TRP);
    if (en) m_tcnt = tick ? 0 : m_tcnt + 1;
    if (tick && !issue)      m_pend = (m_pend < MAXP) ? m_pend + 1 : MAXP;
    else if (issue && !tick) m_pend = m_pend - 1;
    if (m_off >= 0 && m_off < SEQ - 1) noff = m_off + 1;
    else                               noff = go ? 0 : -1;
    m_off = noff;
    if (noff == 0)                          begin m_vld = 1'b1; m_uop = PREA_B; end
    else if (noff == TRP)                   begin m_vld = 1'b1; m_uop = REF_B; end
    else if (noff < 0 && rdy && exe_valid)  begin m_vld = 1'b1; m_uop = exe_uop; end
    else                                    begin m_vld = 1'b0; m_uop = NOP_B; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; exe_valid = 1'b1; exe_uop = rnd_bundle();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (exe_ready !== 1'b0)  begin failures++; $display("FAIL reset_ready: got %b want 0", exe_ready); end
    checks++; if (ddr_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b want 0", ddr_valid); end
    checks++; if (ddr_uop !== NOP_B)   begin failures++; $display("FAIL reset_uop: got %h want %h", ddr_uop, NOP_B); end
    checks++; if (ref_pending !== 4'd0) begin failures++; $display("FAIL reset_pending: got %0d want 0", ref_pending); end
    checks++; if (ref_busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b want 0", ref_busy); end
    checks++; if (ref_issued !== 1'b0) begin failures++; $display("FAIL reset_issued: got %b want 0", ref_issued); end
  endtask

  task automatic test_idle_refresh();
    int prea_c = -1, ref_c = -1, low = 0, n_iss = 0;
    logic [127:0] ref_bus = '0;
    logic ref_vld = 1'b0;
    en = 1'b1;
    do_reset();
    for (int c = 0; c < 140; c++) begin
      #1;
      if (ddr_valid && ddr_uop == PREA_B && prea_c < 0) prea_c = c;
      if (ref_issued) begin
        n_iss++;
        if (ref_c < 0) begin ref_c = c; ref_bus = ddr_uop; ref_vld = ddr_valid; end
      end
      if (!exe_ready) low++;
      clk_step();
    end
    checks++; if (prea_c != 101) begin failures++; $display("FAIL idle_prea_cycle: got %0d want 101", prea_c); end
    checks++; if (ref_c != 106)  begin failures++; $display("FAIL idle_ref_cycle: got %0d want 106", ref_c); end
    checks++; if (ref_bus !== REF_B || ref_vld !== 1'b1) begin failures++; $display("FAIL idle_ref_bundle: got %h v=%b want %h v=1", ref_bus, ref_vld, REF_B); end
    checks++; if (low != 26)     begin failures++; $display("FAIL idle_ready_low: got %0d want 26", low); end
    checks++; if (n_iss != 1)    begin failures++; $display("FAIL idle_ref_count: got %0d want 1", n_iss); end
    checks++; if (ref_pending !== 4'd0) begin failures++; $display("FAIL idle_pending_end: got %0d want 0", ref_pending); end
  endtask

  task automatic test_passthrough();
    bit pv = 1'b0;
    logic [127:0] pu = '0;
    en = 1'b1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      exe_valid = ($urandom_range(0, 3) != 0);
      exe_uop   = rnd_bundle();
      #1;
      checks++; if (exe_ready !== 1'b1) begin failures++; $display("FAIL pass_ready c=%0d: got %b want 1", c, exe_ready); end
      if (c > 0) begin
        checks++; if (ddr_valid !== pv) begin failures++; $display("FAIL pass_valid c=%0d: got %b want %b", c, ddr_valid, pv); end
        checks++; if (ddr_uop !== (pv ? pu : NOP_B)) begin failures++; $display("FAIL pass_uop c=%0d: got %h want %h", c, ddr_uop, pv ? pu : NOP_B); end
      end
      pv = exe_valid; pu = exe_uop;
      clk_step();
    end
    exe_valid = 1'b0;
  endtask

  task automatic test_forced();
    int prea_c = -1, ref_c = -1, n_prea = 0, rdy_hi = 0, p800 = -1, p807 = -1, p900 = -1, prea2 = -1;
    en = 1'b1;
    do_reset();
    exe_valid = 1'b1;
    for (int c = 0; c < 910; c++) begin
      exe_uop = rnd_bundle();
      #1;
      if (ddr_valid && ddr_uop == PREA_B) begin
        if (c <= 900) n_prea++;
        if (prea_c < 0) prea_c = c; else if (prea2 < 0) prea2 = c;
      end
      if (ref_issued && ref_c < 0) ref_c = c;
      if (c < 800 && exe_ready) rdy_hi++;
      if (c == 800) p800 = int'(ref_pending);
      if (c == 807) p807 = int'(ref_pending);
      if (c == 900) p900 = int'(ref_pending);
      clk_step();
    end
    exe_valid = 1'b0;
    checks++; if (rdy_hi != 800) begin failures++; $display("FAIL forced_ready_before: got %0d want 800", rdy_hi); end
    checks++; if (p800 != 8)     begin failures++; $display("FAIL forced_pending_sat: got %0d want 8", p800); end
    checks++; if (prea_c != 801) begin failures++; $display("FAIL forced_prea_cycle: got %0d want 801", prea_c); end
    checks++; if (ref_c != 806)  begin failures++; $display("FAIL forced_ref_cycle: got %0d want 806", ref_c); end
    checks++; if (p807 != 7)     begin failures++; $display("FAIL forced_pending_after: got %0d want 7", p807); end
    checks++; if (n_prea != 1)   begin failures++; $display("FAIL forced_blocked: got %0d PREA want 1", n_prea); end
    checks++; if (p900 != 8)     begin failures++; $display("FAIL forced_pending_resat: got %0d want 8", p900); end
    checks++; if (prea2 != 901)  begin failures++; $display("FAIL forced_prea2_cycle: got %0d want 901", prea2); end
  endtask

  task automatic test_tick_on_ref();
    en = 1'b1;
    do_reset();
    for (int c = 0; c <= 400; c++) begin
      exe_valid = (c <= 392);
      exe_uop   = rnd_bundle();
      #1;
      if (c == 394) begin
        checks++; if (ddr_uop !== PREA_B || ddr_valid !== 1'b1) begin failures++; $display("FAIL tickref_prea: got %h v=%b want %h v=1", ddr_uop, ddr_valid, PREA_B); end
      end
      if (c == 399) begin
        checks++; if (ref_issued !== 1'b1)  begin failures++; $display("FAIL tickref_issued: got %b want 1", ref_issued); end
        checks++; if (ref_pending !== 4'd3) begin failures++; $display("FAIL tickref_pending_ref: got %0d want 3", ref_pending); end
      end
      if (c == 400) begin
        checks++; if (ref_pending !== 4'd3) begin failures++; $display("FAIL tickref_pending_after: got %0d want 3", ref_pending); end
      end
      clk_step();
    end
    exe_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n_iss = 0, n_busy = 0, p99 = -1, p100 = -1, prea_c = -1;
    en = 1'b1;
    do_reset();
    for (int c = 0; c < 103; c++) clk_step();
    #1;
    checks++; if (ref_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", ref_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (exe_ready !== 1'b0 || ddr_valid !== 1'b0 || ref_busy !== 1'b0 || ref_issued !== 1'b0)
      begin failures++; $display("FAIL midrst_ctrl: got rdy=%b vld=%b busy=%b iss=%b want all 0", exe_ready, ddr_valid, ref_busy, ref_issued); end
    checks++; if (ddr_uop !== NOP_B || ref_pending !== 4'd0)
      begin failures++; $display("FAIL midrst_data: got uop=%h pend=%0d want %h pend=0", ddr_uop, ref_pending, NOP_B); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 105; c++) begin
      #1;
      if (c < 100 && ref_issued) n_iss++;
      if (c < 100 && ref_busy) n_busy++;
      if (c == 99) p99 = int'(ref_pending);
      if (c == 100) p100 = int'(ref_pending);
      if (ddr_valid && ddr_uop == PREA_B && prea_c < 0) prea_c = c;
      clk_step();
    end
    checks++; if (n_iss != 0 || n_busy != 0) begin failures++; $display("FAIL midrst_no_ref: got iss=%0d busy=%0d want 0", n_iss, n_busy); end
    checks++; if (p99 != 0 || p100 != 1) begin failures++; $display("FAIL midrst_tick: got p99=%0d p100=%0d want 0/1", p99, p100); end
    checks++; if (prea_c != 101) begin failures++; $display("FAIL midrst_prea_cycle: got %0d want 101", prea_c); end
  endtask

  task automatic test_refresh_disable();
    int bad_pend = 0, bad_rdy = 0, bad_vld = 0, p49 = -1, p50 = -1;
    bit pv = 1'b0;
    en = 1'b1;
    do_reset();
    for (int c = 0; c < 50; c++) clk_step();
    en = 1'b0;
    for (int c = 0; c < 500; c++) begin
      exe_valid = $urandom_range(0, 1);
      exe_uop   = rnd_bundle();
      #1;
      if (ref_pending !== 4'd0) bad_pend++;
      if (exe_ready !== 1'b1) bad_rdy++;
      if (c > 0 && ddr_valid !== pv) bad_vld++;
      pv = exe_valid;
      clk_step();
    end
    checks++; if (bad_pend != 0) begin failures++; $display("FAIL dis_pending: got %0d bad cycles want 0", bad_pend); end
    checks++; if (bad_rdy != 0)  begin failures++; $display("FAIL dis_ready: got %0d bad cycles want 0", bad_rdy); end
    checks++; if (bad_vld != 0)  begin failures++; $display("FAIL dis_valid: got %0d bad cycles want 0", bad_vld); end
    en = 1'b1; exe_valid = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      #1;
      if (k == 49) p49 = int'(ref_pending);
      if (k == 50) p50 = int'(ref_pending);
      clk_step();
    end
    checks++; if (p49 != 0 || p50 != 1) begin failures++; $display("FAIL dis_frozen_count: got p49=%0d p50=%0d want 0/1", p49, p50); end
  endtask

  task automatic test_random();
    bit go, rdy;
    int dens = 50;
    en = 1'b1;
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) dens = (c % 2000 == 0) ? 100 : $urandom_range(5, 95);
      if ($urandom_range(0, 299) == 0) en = ~en;
      exe_valid = ($urandom_range(1, 100) <= dens);
      exe_uop   = rnd_bundle();
      #1;
      go  = (m_pend > 0) && (!exe_valid || m_pend == MAXP);
      rdy = (m_off < 0) && !go;
      checks++; if (exe_ready !== rdy) begin failures++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, exe_ready, rdy); end
      checks++; if (ref_busy !== (m_off >= 0)) begin failures++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, ref_busy, m_off >= 0); end
      checks++; if (ref_issued !== (m_off == TRP)) begin failures++; $display("FAIL rnd_issued c=%0d: got %b want %b", c, ref_issued, m_off == TRP); end
      checks++; if (ref_pending !== 4'(m_pend)) begin failures++; $display("FAIL rnd_pending c=%0d: got %0d want %0d", c, ref_pending, m_pend); end
      checks++; if (ddr_valid !== m_vld) begin failures++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, ddr_valid, m_vld); end
      checks++; if (ddr_uop !== m_uop) begin failures++; $display("FAIL rnd_uop c=%0d: got %h want %h", c, ddr_uop, m_uop); end
      model_step(go, rdy);
      clk_step();
    end
    exe_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_passthrough();
    test_forced();
    test_tick_on_ref();
    test_reset_mid();
    test_refresh_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_refresh_arbiter.md
DDR_REFRESH_ARBITER -- requirements
Module: ddr_refresh_arbiter

Interface
REQ-001 Parameter TREFI, default 7800, sets the number of clk cycles between refresh-due ticks.
REQ-002 Parameter TRP, default 12, sets the wait in cycles from issuing PRE-all to issuing REF.
REQ-003 Parameter TRFC, default 280, sets the wait in cycles after REF before program traffic may resume.
REQ-004 Parameter MAX_POSTPONE, default 8 (range 1..15), sets the pending-refresh count that forces a refresh.
REQ-005 clk  in  1  single clock for the whole block.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 refresh_en  in  1  enables tick generation; when 0, the counter holds and no new pending refreshes accrue.
REQ-008 exe_valid  in  1  the execute stage presents a 4-way uop bundle.
REQ-009 exe_uop  in  DDR_UOP_WIDTH*4  program uop bundle, slot i at bits [i*DDR_UOP_WIDTH +: DDR_UOP_WIDTH].
REQ-010 exe_ready  out  1  the bundle is accepted this cycle when exe_valid && exe_ready.
REQ-011 ddr_valid  out  1  bundle valid toward ddr_pipeline.
REQ-012 ddr_uop  out  DDR_UOP_WIDTH*4  bundle toward ddr_pipeline.
REQ-013 ref_pending  out  4  current postponed-refresh count.
REQ-014 ref_busy  out  1  high in any state other than IDLE.
REQ-015 ref_issued  out  1  one-cycle pulse in the cycle the REF bundle is on ddr_uop.

Function
REQ-016 Tick counter: counts 0..TREFI-1 while refresh_en=1; on reaching TREFI-1 it wraps to 0 and generates a tick.
REQ-017 Each tick increments ref_pending, saturating at MAX_POSTPONE.
REQ-018 If a tick and a REF issue occur in the same cycle, ref_pending is unchanged.
REQ-019 FSM states are IDLE, PREA, WAIT_RP, REF, WAIT_RFC; the state is registered.
REQ-020 Transition IDLE->PREA occurs when ref_pending>0 and either exe_valid=0 (opportunistic) or ref_pending==MAX_POSTPONE (forced).
REQ-021 exe_ready=1 only in IDLE when the IDLE->PREA condition is false; an accepted bundle is never dropped or split.
REQ-022 In IDLE with an accepted bundle: ddr_valid=1 and ddr_uop=exe_uop, registered, so output appears 1 cycle after acceptance.
REQ-023 In IDLE with no accepted bundle: ddr_valid=0 and every slot is IS_NOP=1.
REQ-024 PREA lasts 1 cycle: the output bundle has slot0 IS_PRE=1 and PRE_ALL=1, slots 1-3 IS_NOP=1, ddr_valid=1; then WAIT_RP.
REQ-025 WAIT_RP holds for TRP-1 cycles with NOP bundles, ddr_valid=0; then REF.
REQ-026 REF lasts 1 cycle: slot0 IS_REF=1, other slots NOP, ddr_valid=1, ref_issued=1, ref_pending decremented; then WAIT_RFC.
REQ-027 WAIT_RFC holds for TRFC-1 cycles with NOP bundles; it then returns to IDLE, or goes directly to PREA if the IDLE->PREA condition already holds.
REQ-028 A single down-counter, width clog2(max(TRP,TRFC)), serves both wait states; it is loaded on entry to each wait state.
REQ-029 Generated refresh uops use IS_RANK=0, HBM_CHANNEL=0, and all register-id fields 0.
REQ-030 If refresh_en falls during a refresh sequence, the in-flight sequence completes; ref_pending is not cleared.

Reset
REQ-031 While rst=0: state=IDLE, tick counter=0, wait counter=0, ref_pending=0, ddr_valid=0, ddr_uop=all-slot NOP, exe_ready=0, ref_busy=0, ref_issued=0.
REQ-032 Assertion of rst mid-sequence aborts the sequence immediately; no REF is issued after release without a new tick.

Structure
REQ-033 FSM state encoding and the NOP/PREA/REF bundle constants live in the shared encoding include, alongside the existing uop field macros.
REQ-034 The tick counter plus postpone logic is one sub-module, refresh_tick_gen; all other logic is flat in ddr_refresh_arbiter.

Verification
Bench parameters for all scenarios: TREFI=100, TRP=5, TRFC=20, MAX_POSTPONE=8.
REQ-035 Idle bus, refresh_en=1 from reset -> PREA bundle at cycle 100+1, REF exactly 5 cycles later, exe_ready=0 for 26 cycles total, ref_pending returns to 0.
REQ-036 exe_valid held at 1 continuously -> no refresh until ref_pending==8 (about 800 cycles), then forced PREA/REF, then 7 more opportunistic-blocked.
REQ-037 exe_valid=1 with exe_uop=A in IDLE -> ddr_uop=A with ddr_valid=1 on the next cycle, bit-exact.
REQ-038 Tick coincides with the REF cycle while ref_pending=3 -> ref_pending remains 3.
REQ-039 rst pulsed low during WAIT_RP -> outputs at reset values immediately; after release, no REF issued before the next tick.
REQ-040 refresh_en=0 for 500 cycles -> ref_pending stays 0, tick counter frozen, exe_ready=1 throughout.
